// File: rtl/loop_sequencer.sv
// loop_sequencer: autonomous sequencer for the register-file / operand-mux / ALU datapath.
// Runs "acc = 0; idx = 0; repeat N { acc += idx; idx += step }" and then presents
// acc on read port 1 and idx on read port 2 for readout.
// Every op is held on the datapath for OP_CYCLES clocks, and all outputs are registered.
// Optional feature macro: OVF_ABORT_EN. When defined, an ALU overflow on the last cycle
// of an ADD stops the loop early and sets err.
module loop_sequencer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ITER_W    = 8,
  parameter int unsigned OP_CYCLES = 3,
  parameter logic [3:0]  ALU_ADD   = 4'b0010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_count,
  input  logic [DATA_W-1:0] step,
  input  logic [ADDR_W-1:0] acc_reg,
  input  logic [ADDR_W-1:0] idx_reg,
  input  logic              Overflow,
  output logic [ADDR_W-1:0] ReadRgAddr1,
  output logic [ADDR_W-1:0] ReadRgAddr2,
  output logic [ADDR_W-1:0] WriteRgAddr,
  output logic              wr_en,
  output logic [DATA_W-1:0] immediate,
  output logic              sel,
  output logic [3:0]        Control,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_idx,
  output logic              err
);

  localparam int unsigned CNT_W = (OP_CYCLES > 2) ? $clog2(OP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_ACC,
    S_INIT_IDX,
    S_ADD,
    S_INC,
    S_READOUT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
  logic              op_last;
  logic [ITER_W-1:0] iter_d, n_q, n_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] acc_q, acc_d, idx_q, idx_d;
  logic              err_d;

  logic [ADDR_W-1:0] rd1_d, rd2_d, wr_d;
  logic              wr_en_d, sel_d, busy_d, done_d;
  logic [DATA_W-1:0] imm_d;
  logic [3:0]        ctrl_d;

  assign op_last = (op_cnt_q == CNT_LAST);

`ifndef OVF_ABORT_EN
  logic unused_overflow;
  assign unused_overflow = Overflow;
`endif

  // Next-state logic: op timing, run-parameter latching, iteration count and abort flag.
  always_comb begin
    state_d  = state_q;
    op_cnt_d = op_last ? '0 : op_cnt_q + CNT_W'(1);
    iter_d   = iter_idx;
    n_d      = n_q;
    step_d   = step_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
`ifdef OVF_ABORT_EN
    err_d    = err;
`else
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        op_cnt_d = '0;
        if (start) begin
          state_d = S_INIT_ACC;
          n_d     = iter_count;
          step_d  = step;
          acc_d   = acc_reg;
          idx_d   = idx_reg;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_INIT_ACC: begin
        if (op_last) state_d = S_INIT_IDX;
      end
      S_INIT_IDX: begin
        if (op_last) state_d = (n_q == '0) ? S_READOUT : S_ADD;
      end
      S_ADD: begin
        if (op_last) begin
`ifdef OVF_ABORT_EN
          if (Overflow) begin
            state_d = S_READOUT;
            err_d   = 1'b1;
          end else begin
            state_d = S_INC;
          end
`else
          state_d = S_INC;
`endif
        end
      end
      S_INC: begin
        if (op_last) begin
          iter_d  = iter_idx + ITER_W'(1);
          state_d = (iter_idx + ITER_W'(1) == n_q) ? S_READOUT : S_ADD;
        end
      end
      S_READOUT: begin
        if (op_last) state_d = S_DONE;
      end
      S_DONE: begin
        op_cnt_d = '0;
        state_d  = S_IDLE;
      end
      default: begin
        op_cnt_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state register.
  // Uses the next-value register selections so the first op sees the values latched on start.
  always_comb begin
    rd1_d   = '0;
    rd2_d   = '0;
    wr_d    = '0;
    wr_en_d = 1'b0;
    imm_d   = '0;
    sel_d   = 1'b0;
    ctrl_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_INIT_ACC: begin
        wr_d    = acc_d;
        sel_d   = 1'b1;
        wr_en_d = 1'b1;
        ctrl_d  = ALU_ADD;
        busy_d  = 1'b1;
      end
      S_INIT_IDX: begin
        wr_d    = idx_d;
        sel_d   = 1'b1;
        wr_en_d = 1'b1;
        ctrl_d  = ALU_ADD;
        busy_d  = 1'b1;
      end
      S_ADD: begin
        rd1_d   = acc_d;
        rd2_d   = idx_d;
        wr_d    = acc_d;
        wr_en_d = 1'b1;
        ctrl_d  = ALU_ADD;
        busy_d  = 1'b1;
      end
      S_INC: begin
        rd1_d   = idx_d;
        wr_d    = idx_d;
        sel_d   = 1'b1;
        imm_d   = step_d;
        wr_en_d = 1'b1;
        ctrl_d  = ALU_ADD;
        busy_d  = 1'b1;
      end
      S_READOUT: begin
        rd1_d   = acc_d;
        rd2_d   = idx_d;
        ctrl_d  = ALU_ADD;
        busy_d  = 1'b1;
      end
      S_DONE: begin
        rd1_d   = acc_d;
        rd2_d   = idx_d;
        ctrl_d  = ALU_ADD;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, run parameters and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_cnt_q    <= '0;
      n_q         <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      iter_idx    <= '0;
      err         <= 1'b0;
      ReadRgAddr1 <= '0;
      ReadRgAddr2 <= '0;
      WriteRgAddr <= '0;
      wr_en       <= 1'b0;
      immediate   <= '0;
      sel         <= 1'b0;
      Control     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_cnt_q    <= op_cnt_d;
      n_q         <= n_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      iter_idx    <= iter_d;
      err         <= err_d;
      ReadRgAddr1 <= rd1_d;
      ReadRgAddr2 <= rd2_d;
      WriteRgAddr <= wr_d;
      wr_en       <= wr_en_d;
      immediate   <= imm_d;
      sel         <= sel_d;
      Control     <= ctrl_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: drives loop_sequencer against a behavioural register file / ALU
// and compares each run with the loop result computed arithmetically from N and step.
module tb_loop_sequencer;

  localparam int OPC = 3;
  localparam logic [3:0] ADD_CODE = 4'b0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  iter_count;
  logic [15:0] step;
  logic [3:0]  acc_reg, idx_reg;
  logic        Overflow = 1'b0;
  logic [3:0]  ReadRgAddr1, ReadRgAddr2, WriteRgAddr;
  logic        wr_en, sel, busy, done, err;
  logic [15:0] immediate;
  logic [3:0]  Control;
  logic [7:0]  iter_idx;

  int checks = 0;
  int errors = 0;

  // Datapath model state and run monitors.
  logic [15:0] regs [0:15];
  logic [47:0] prev_sig = '0;
  int hold = 0;
  int wr_cyc = 0, add_cyc = 0, busy_cyc = 0, done_cnt = 0;

  loop_sequencer #(
    .DATA_W(16), .ADDR_W(4), .ITER_W(8), .OP_CYCLES(OPC), .ALU_ADD(ADD_CODE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .iter_count(iter_count), .step(step),
    .acc_reg(acc_reg), .idx_reg(idx_reg), .Overflow(Overflow),
    .ReadRgAddr1(ReadRgAddr1), .ReadRgAddr2(ReadRgAddr2), .WriteRgAddr(WriteRgAddr),
    .wr_en(wr_en), .immediate(immediate), .sel(sel), .Control(Control),
    .busy(busy), .done(done), .iter_idx(iter_idx), .err(err)
  );

  always #5 clk = ~clk;

  // Register file + operand mux + ALU; an op commits its result once, on its last held cycle.
  always @(negedge clk) begin
    logic [15:0] rd1, rd2, b, res;
    logic [47:0] sig;
    rd1 = regs[ReadRgAddr1];
    rd2 = regs[ReadRgAddr2];
    b   = sel ? immediate : rd2;
    res = rd1 + b;
    Overflow = (rd1[15] == b[15]) && (res[15] != rd1[15]);
    sig = {ReadRgAddr1, ReadRgAddr2, WriteRgAddr, 3'b0, wr_en, immediate, 3'b0, sel, Control, 8'h0};
    if (sig == prev_sig) hold++;
    else hold = 1;
    prev_sig = sig;
    if (wr_en) wr_cyc++;
    if (wr_en && !sel) add_cyc++;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (wr_en && hold == OPC && WriteRgAddr != 4'd0) regs[WriteRgAddr] = res;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Loop semantics from first principles: acc sums successive idx values, idx steps by stp.
  function automatic void model(input int n, input logic [15:0] stp,
                                output logic [15:0] acc, output logic [15:0] idx,
                                output int iters, output int ops, output int adds,
                                output bit ab);
    acc = 16'h0; idx = 16'h0; iters = 0; ops = 0; adds = 0; ab = 1'b0;
    for (int i = 0; i < n; i++) begin
`ifdef OVF_ABORT_EN
      logic [16:0] s;
      bit ovf;
      s   = {1'b0, acc} + {1'b0, idx};
      ovf = (acc[15] == idx[15]) && (s[15] != acc[15]);
`endif
      acc = acc + idx;
      ops++;
      adds++;
`ifdef OVF_ABORT_EN
      if (ovf) begin
        ab = 1'b1;
        break;
      end
`endif
      idx = idx + stp;
      iters++;
      ops++;
    end
  endfunction

  task automatic do_run(input string name, input int n, input logic [15:0] stp,
                        input logic [3:0] a, input logic [3:0] x, input bit pulse_mid,
                        output logic [15:0] obs_acc, output logic [15:0] obs_idx);
    logic [15:0] e_acc, e_idx;
    int e_iters, e_ops, e_adds, e_cyc, t;
    bit e_ab;
    model(n, stp, e_acc, e_idx, e_iters, e_ops, e_adds, e_ab);
    e_cyc = (3 + e_ops) * OPC;
    @(posedge clk); #2;
    start = 1'b1; iter_count = 8'(n); step = stp; acc_reg = a; idx_reg = x;
    wr_cyc = 0; add_cyc = 0; busy_cyc = 0; done_cnt = 0;
    @(posedge clk); #2;
    start = 1'b0;
    iter_count = 8'($urandom); step = 16'($urandom);
    acc_reg = 4'($urandom); idx_reg = 4'($urandom);
    t = 0;
    while (done !== 1'b1 && t < 2000) begin
      @(posedge clk); #2;
      t++;
      start = pulse_mid && (t == 10);
    end
    start = 1'b0;
    obs_acc = regs[ReadRgAddr1];
    obs_idx = regs[ReadRgAddr2];
    check({name, "_done_latency"}, t, e_cyc);
    check({name, "_rd1_addr"}, ReadRgAddr1, a);
    check({name, "_rd2_addr"}, ReadRgAddr2, x);
    check({name, "_acc"}, obs_acc, e_acc);
    check({name, "_idx"}, obs_idx, e_idx);
    check({name, "_done_busy"}, busy, 1'b0);
    check({name, "_done_wr_en"}, wr_en, 1'b0);
    check({name, "_done_ctrl"}, Control, ADD_CODE);
    check({name, "_iter_idx"}, iter_idx, e_iters);
    check({name, "_err"}, err, e_ab);
    check({name, "_wr_cycles"}, wr_cyc, (2 + e_ops) * OPC);
    check({name, "_add_cycles"}, add_cyc, e_adds * OPC);
    check({name, "_busy_cycles"}, busy_cyc, e_cyc);
    @(posedge clk); #2;
    check({name, "_idle_done"}, done, 1'b0);
    check({name, "_idle_dp"}, {ReadRgAddr1, ReadRgAddr2, WriteRgAddr, wr_en, sel, Control}, '0);
    check({name, "_idle_imm"}, immediate, 16'h0);
    check({name, "_err_hold"}, err, e_ab);
    repeat (2 * OPC) @(posedge clk);
    #2;
    check({name, "_single_done"}, done_cnt, 1);
    check({name, "_stays_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [15:0] ra, ri;
    int n;
    logic [3:0] a;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;
    rst = 1'b1; start = 1'b0; iter_count = '0; step = '0; acc_reg = '0; idx_reg = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_dp", {ReadRgAddr1, ReadRgAddr2, WriteRgAddr, wr_en, sel, Control}, '0);
    check("reset_iter_err", {iter_idx, err}, '0);
    rst = 1'b1;

    do_run("t1", 10, 16'd1, 4'd1, 4'd2, 1'b1, ra, ri);
    check("t1_rd1_45", ra, 16'd45);
    check("t1_rd2_10", ri, 16'd10);

    do_run("t2", 0, 16'd1, 4'd3, 4'd4, 1'b0, ra, ri);
    check("t2_rd1_0", ra, 16'd0);
    check("t2_rd2_0", ri, 16'd0);

    do_run("t3", 5, 16'd2, 4'd7, 4'd9, 1'b1, ra, ri);
    check("t3_rd1_20", ra, 16'd20);
    check("t3_rd2_10", ri, 16'd10);

    // Reset asserted in the middle of the third ADD op.
    @(posedge clk); #2;
    start = 1'b1; iter_count = 8'd10; step = 16'd1; acc_reg = 4'd5; idx_reg = 4'd6;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    check("t5_in_add", {wr_en, sel, WriteRgAddr}, {1'b1, 1'b0, 4'd5});
    rst = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_dp", {ReadRgAddr1, ReadRgAddr2, WriteRgAddr, wr_en, sel, Control, done}, '0);
    check("t5_rst_imm_iter", {immediate, iter_idx, err}, '0);
    @(posedge clk); #2;
    rst = 1'b1;
    do_run("t5", 3, 16'd1, 4'd5, 4'd6, 1'b0, ra, ri);
    check("t5_rd1_3", ra, 16'd3);
    check("t5_rd2_3", ri, 16'd3);

    do_run("t6", 4, 16'h3000, 4'd2, 4'd8, 1'b0, ra, ri);
`ifdef OVF_ABORT_EN
    check("t6_rd2", ri, 16'h6000);
`else
    check("t6_rd2", ri, 16'hC000);
`endif

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(0, 12);
      a = 4'($urandom_range(1, 15));
      do_run("rnd", n, 16'($urandom), a, 4'((a % 15) + 1), k[0], ra, ri);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
